note_tone_gen: RTL and testbench

Downstream consumer of the keyboard controller's note/octave/flat/instrument outputs. Converts the currently held key into a pitched, enveloped audio sample stream at a fixed sample rate (50 kHz at 50 MHz clk). It uses a 24-bit phase accumulator, a square or sawtooth waveform selected by instrument, and an attack/sustain/release envelope FSM. Output feeds the audio codec serializer.

---
 rtl/tone_pkg.sv | 46 ++++
 rtl/tone_envelope.sv | 109 ++++++++++
 rtl/note_tone_gen.sv | 169 ++++++++++++++++
 tb/tb_note_tone_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared types, constants and helpers for the note tone generator.
//
//   env_state_t     envelope FSM state (IDLE, ATTACK, SUSTAIN, RELEASE)
//   WAVE_AMP        peak waveform amplitude before gain scaling
//   PHASE_INC_BASE  octave-1 phase increments for a 24-bit accumulator at 50 kHz
//   SEMI_IDX        (note, flat) -> semitone index 0..11 into PHASE_INC_BASE
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int WAVE_AMP = 16384;

    // round(f * 2^24 / 50000) for C..B of the octave that contains A = 220 Hz.
    // Index is the semitone above C.
    localparam logic [23:0] PHASE_INC_BASE [12] = '{
        24'd43893, 24'd46504, 24'd49269, 24'd52198,
        24'd55302, 24'd58591, 24'd62075, 24'd65766,
        24'd69677, 24'd73820, 24'd78209, 24'd82860
    };

    // note: 1..7 = C,D,E,F,G,A,B (0 = no key, maps to index 0).
    function automatic logic [3:0] SEMI_IDX(input logic [2:0] note, input logic flat);
        logic [3:0] nat_idx;
        case (note)
            3'd1:    nat_idx = 4'd0;
            3'd2:    nat_idx = 4'd2;
            3'd3:    nat_idx = 4'd4;
            3'd4:    nat_idx = 4'd5;
            3'd5:    nat_idx = 4'd7;
            3'd6:    nat_idx = 4'd9;
            3'd7:    nat_idx = 4'd11;
            default: nat_idx = 4'd0;
        endcase
        // C-flat has no lower neighbour in the table, so it stays on C.
        if (flat && (nat_idx != 4'd0)) begin
            return nat_idx - 4'd1;
        end
        return nat_idx;
    endfunction

endpackage

// File: rtl/tone_envelope.sv
// tone_envelope: attack/sustain/release envelope FSM and 8-bit gain register.
// Updates only on sample ticks.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   tick         one-cycle sample strobe; all state changes happen here
//   key_on       a valid key is currently held
//   state        registered envelope state
//   state_next   envelope state after this cycle (equals state off-tick)
//   gain         gain after this cycle's update (equals the register off-tick)
//   restart      tick-qualified strobe: the phase accumulator must clear to 0
module tone_envelope
    import tone_pkg::*;
#(
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_on,
    output env_state_t state,
    output env_state_t state_next,
    output logic [7:0] gain,
    output logic       restart
);

    localparam logic [8:0] ATT_STEP = 9'(ATTACK_STEP);
    localparam logic [8:0] REL_STEP = 9'(RELEASE_STEP);

    env_state_t state_q, state_d;
    logic [7:0] gain_q, gain_d;
    logic [8:0] gain_sum;
    logic [7:0] gain_up;
    logic [7:0] gain_down;

    // Saturating gain steps, computed once and shared by every state.
    always_comb begin
        gain_sum  = {1'b0, gain_q} + ATT_STEP;
        gain_up   = (gain_sum > 9'd255) ? 8'd255 : gain_sum[7:0];
        gain_down = ({1'b0, gain_q} > REL_STEP) ? (gain_q - REL_STEP[7:0]) : 8'd0;
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        restart = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (key_on) begin
                        state_d = ATTACK;
                        gain_d  = 8'd0;
                        restart = 1'b1;
                    end
                end
                ATTACK: begin
                    if (key_on) begin
                        gain_d = gain_up;
                        if (gain_up == 8'd255) begin
                            state_d = SUSTAIN;
                        end
                    end else begin
                        state_d = RELEASE;
                        gain_d  = gain_down;
                    end
                end
                SUSTAIN: begin
                    if (!key_on) begin
                        state_d = RELEASE;
                        gain_d  = gain_down;
                    end
                end
                RELEASE: begin
                    if (key_on) begin
                        // Re-press: climb from the current level, no phase reset.
                        state_d = ATTACK;
                        gain_d  = gain_up;
                    end else begin
                        gain_d = gain_down;
                        if (gain_down == 8'd0) begin
                            state_d = IDLE;
                            restart = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    gain_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gain_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;
    assign gain       = gain_d;

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: turns the held key (note/octave/flat/instrument) into an enveloped
// square or sawtooth sample stream at clk / SAMPLE_DIV.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   note          1..7 = C..B, 0 = no key
//   octave        1..4, 0 = no key, 5..7 behave as 4
//   flat          lower the note by one semitone
//   instrument    0 = square, 1 = sawtooth
//   sample        signed 16-bit audio sample
//   sample_valid  one-cycle strobe in the cycle after each sample tick
//   active        envelope is not IDLE (updates with sample)
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 1000,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         note,
    input  logic [2:0]         octave,
    input  logic               flat,
    input  logic               instrument,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               active
);

    localparam int unsigned      CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic signed [15:0] AMP_POS = 16'(WAVE_AMP);
    localparam logic signed [15:0] AMP_NEG = 16'(-WAVE_AMP);

    // ---------------------------------------------------------------- sample tick
    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------- key decode
    logic             key_on;
    logic [3:0]       semi;
    logic [1:0]       oct_shift;
    logic [ACC_W-1:0] inc_sel;

    always_comb begin
        key_on = (note != 3'd0) && (octave != 3'd0);
        semi   = SEMI_IDX(note, flat);
        if (octave >= 3'd4) begin
            oct_shift = 2'd3;
        end else if (octave == 3'd0) begin
            oct_shift = 2'd0;
        end else begin
            oct_shift = 2'(octave - 3'd1);
        end
        inc_sel = ACC_W'(PHASE_INC_BASE[semi]) << oct_shift;
    end

    // ---------------------------------------------------------------- envelope
    env_state_t env_state;
    env_state_t env_state_next;
    logic [7:0] env_gain;
    logic       restart;

    tone_envelope #(
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_envelope (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key_on     (key_on),
        .state      (env_state),
        .state_next (env_state_next),
        .gain       (env_gain),
        .restart    (restart)
    );

    // ---------------------------------------------------------------- phase accumulator
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;

    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        if (restart) begin
            // Fresh press from IDLE, or end of the release tail.
            acc_d = '0;
            if (env_state == IDLE) begin
                inc_d = inc_sel;
            end
        end else if (tick && (env_state != IDLE)) begin
            if (key_on) begin
                // Legato: retune without touching the phase.
                inc_d = inc_sel;
                acc_d = acc_q + inc_sel;
            end else begin
                // Release tail keeps the pitch of the last held note.
                acc_d = acc_q + inc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            inc_q <= '0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
        end
    end

    // ---------------------------------------------------------------- waveform and gain
    logic signed [15:0] square_wave;
    logic signed [15:0] saw_wave;
    logic signed [15:0] wave;
    logic signed [8:0]  gain_s;
    logic signed [24:0] product;
    logic signed [15:0] sample_d;

    // Built from the post-update accumulator and gain so the sample registered on the
    // tick edge already reflects that tick.
    always_comb begin
        square_wave = acc_d[ACC_W-1] ? AMP_NEG : AMP_POS;
        // Flipping the MSB turns the unsigned ramp into a signed one centred on zero.
        saw_wave    = $signed({~acc_d[ACC_W-1], acc_d[ACC_W-2 -: 15]}) >>> 1;
        wave        = instrument ? saw_wave : square_wave;
        gain_s      = $signed({1'b0, env_gain});
        product     = 25'(wave) * 25'(gain_s);
        sample_d    = 16'(product >>> 8);
    end

    logic signed [15:0] sample_q;
    logic               sample_valid_q;
    logic               active_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            sample_valid_q <= tick;
            if (tick) begin
                sample_q <= sample_d;
                active_q <= (env_state_next != IDLE);
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign active       = active_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen: each sample period the stimulus drives the key
// inputs, steps a behavioural model and queues the expected sample; a monitor process
// pops and compares whenever sample_valid is seen.
module tb_note_tone_gen;

    localparam int SD      = 16;
    localparam int ACC_MOD = 1 << 24;
    localparam int HALF    = 1 << 23;

    logic               clk;
    logic               reset;
    logic [2:0]         note;
    logic [2:0]         octave;
    logic               flat;
    logic               instrument;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               active;

    note_tone_gen #(
        .SAMPLE_DIV   (SD),
        .ACC_W        (24),
        .ATTACK_STEP  (8),
        .RELEASE_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .note         (note),
        .octave       (octave),
        .flat         (flat),
        .instrument   (instrument),
        .sample       (sample),
        .sample_valid (sample_valid),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int a;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   n_samples;
    int   base_tab[12];

    // Model: envelope phase 0 silent, 1 rising, 2 holding, 3 falling.
    int m_phase;
    int m_gain;
    int m_acc;
    int m_inc;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic int inc_of(input int n, input int o, input bit f);
        int nat;
        int idx;
        int oc;
        case (n)
            2:       nat = 2;
            3:       nat = 4;
            4:       nat = 5;
            5:       nat = 7;
            6:       nat = 9;
            7:       nat = 11;
            default: nat = 0;
        endcase
        idx = (f && nat > 0) ? nat - 1 : nat;
        oc  = (o > 4) ? 4 : o;
        if (oc == 0) return 0;
        return base_tab[idx] * (1 << (oc - 1));
    endfunction

    function automatic void model_clear();
        m_phase = 0;
        m_gain  = 0;
        m_acc   = 0;
        m_inc   = 0;
    endfunction

    function automatic void model_tick(input bit kon, input int isel, input bit saw,
                                       output exp_t e);
        int wave;
        case (m_phase)
            0: begin
                if (kon) begin
                    m_phase = 1;
                    m_acc   = 0;
                    m_gain  = 0;
                    m_inc   = isel;
                end
            end
            1, 2: begin
                if (kon) begin
                    m_inc = isel;
                    m_acc = (m_acc + isel) % ACC_MOD;
                    if (m_phase == 1) begin
                        m_gain = (m_gain + 8 > 255) ? 255 : m_gain + 8;
                        if (m_gain == 255) m_phase = 2;
                    end
                end else begin
                    m_phase = 3;
                    m_acc   = (m_acc + m_inc) % ACC_MOD;
                    m_gain  = (m_gain - 4 < 0) ? 0 : m_gain - 4;
                end
            end
            default: begin
                if (kon) begin
                    m_phase = 1;
                    m_inc   = isel;
                    m_acc   = (m_acc + isel) % ACC_MOD;
                    m_gain  = (m_gain + 8 > 255) ? 255 : m_gain + 8;
                end else begin
                    m_acc  = (m_acc + m_inc) % ACC_MOD;
                    m_gain = (m_gain - 4 < 0) ? 0 : m_gain - 4;
                    if (m_gain == 0) begin
                        m_phase = 0;
                        m_acc   = 0;
                    end
                end
            end
        endcase
        if (saw) wave = ((m_acc / 256) - 32768) >>> 1;
        else     wave = (m_acc >= HALF) ? -16384 : 16384;
        e.s = (wave * m_gain) >>> 8;
        e.a = (m_phase != 0) ? 1 : 0;
    endfunction

    // One sample period: drive inputs, queue the expected sample for the tick that
    // will sample them, then wait out the period.
    task automatic period(input int n, input int o, input bit f, input bit ins,
                          input bit chk_lat);
        exp_t e;
        int   first;
        note       = 3'(n);
        octave     = 3'(o);
        flat       = f;
        instrument = ins;
        model_tick((n != 0) && (o != 0), inc_of(n, o, f), ins, e);
        exp_q.push_back(e);
        first = -1;
        for (int k = 1; k <= SD; k++) begin
            @(posedge clk);
            #1;
            if (chk_lat && first < 0 && sample_valid) first = k;
        end
        if (chk_lat) check_int("first_valid_latency", first, SD);
    endtask

    task automatic hold(input int cnt, input int n, input int o, input bit f, input bit ins);
        for (int i = 0; i < cnt; i++) period(n, o, f, ins, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_sample"}, int'(sample), 0);
        check_int({tag, "_valid"}, int'(sample_valid), 0);
        check_int({tag, "_active"}, int'(active), 0);
    endtask

    task automatic mid_reset();
        repeat (SD / 2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && sample_valid) begin
                n_samples++;
                check_int($sformatf("expected_available[%0d]", n_samples),
                          (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_int($sformatf("sample[%0d]", n_samples), int'(sample), e.s);
                    check_int($sformatf("active[%0d]", n_samples), int'(active), e.a);
                end
            end
        end
    endtask

    initial begin
        int left;
        int rn;
        int ro;
        int rf;
        int ri;

        checks    = 0;
        errors    = 0;
        n_samples = 0;
        for (int i = 0; i < 12; i++) begin
            real f;
            f = 220.0 * $pow(2.0, real'(i - 9) / 12.0);
            base_tab[i] = $rtoi(f * 16777216.0 / 50000.0 + 0.5);
        end
        model_clear();

        reset      = 1'b1;
        note       = 3'd0;
        octave     = 3'd0;
        flat       = 1'b0;
        instrument = 1'b0;
        fork
            monitor_loop();
        join_none

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // A, octave 1, square: press, attack to 255, sustain.
        period(6, 1, 1'b0, 1'b0, 1'b1);
        hold(39, 6, 1, 1'b0, 1'b0);
        // Key off: full release to IDLE, then some silence.
        hold(70, 0, 0, 1'b0, 1'b0);
        // Sawtooth, octave 2 then octave 7 (clamps to 4).
        hold(12, 6, 2, 1'b0, 1'b1);
        hold(30, 6, 7, 1'b0, 1'b1);
        // Partial release, then re-press mid-tail.
        hold(39, 0, 3, 1'b0, 1'b1);
        hold(5, 2, 3, 1'b0, 1'b1);
        // Flats, including C-flat and F-flat, retuned legato.
        hold(8, 1, 2, 1'b1, 1'b1);
        hold(8, 4, 1, 1'b1, 1'b1);
        hold(8, 7, 4, 1'b1, 1'b0);

        left = 0;
        for (int p = 0; p < 160; p++) begin
            if (left == 0) begin
                rn   = $urandom_range(0, 7);
                ro   = $urandom_range(0, 7);
                rf   = $urandom_range(0, 1);
                ri   = $urandom_range(0, 1);
                left = $urandom_range(1, 45);
            end
            if ($urandom_range(0, 9) == 0) ri = 1 - ri;
            period(rn, ro, rf[0], ri[0], 1'b0);
            left--;
        end

        hold(10, 5, 3, 1'b0, 1'b0);
        mid_reset();
        period(3, 2, 1'b0, 1'b1, 1'b1);
        hold(10, 3, 2, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        check_int("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
